// File: rtl/stackcache_pkg.sv
// Shared types and sizing for the stack-cache line transfer responder.
package stackcache_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned LINE_IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned SLOT_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } xfer_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W-1:0]     base;
    logic [LINE_IDX_W-1:0] start;
    logic [SLOT_W-1:0]     slot;
  } line_cmd_t;

endpackage

// File: rtl/stack_line_xfer_responder_if.sv
// Word-level backing-memory port: master is the responder, slave is the memory.
interface stack_line_xfer_responder_if;
  import stackcache_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/stack_line_xfer_responder_word_counter.sv
// Modulo-LINE_WORDS word counter with a sticky terminal flag, gated by clk_en.
module stack_line_word_counter
  import stackcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [LINE_IDX_W-1:0] count,
  output logic                  full
);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count <= '0;
      full  <= 1'b0;
    end else if (clk_en) begin
      if (clr) begin
        count <= '0;
        full  <= 1'b0;
      end else if (inc && !full) begin
        count <= count + 1'b1;
        // Count wraps to 0 on the last word; full remembers that a whole line went by.
        if (count == LINE_IDX_W'(LINE_WORDS - 1)) full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_line_xfer_responder.sv
// Stack-cache line fetch/writeback servicer over a word-wide memory port.
// Build option: STACKCACHE_XFER_CRITICAL_WORD_FIRST_EN starts transfers at the addressed word.
module stack_line_xfer_responder
  import stackcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         clk_en,
  input  logic                         sync_rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [SLOT_W-1:0]            req_slot,
  input  logic [LINE_WORDS*DATA_W-1:0] req_line_data,
  stack_line_xfer_responder_if.master  mem,
  output logic                         fill_valid,
  output logic [SLOT_W-1:0]            fill_slot,
  output logic [LINE_IDX_W-1:0]        fill_index,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         done_valid,
  output logic [SLOT_W-1:0]            done_slot,
  output logic                         done_write
);

  xfer_state_t                       state_q;
  line_cmd_t                         cmd_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;

  logic [LINE_IDX_W-1:0] issue_cnt, resp_cnt, issue_idx, start_idx;
  logic                  issue_full, resp_full;
  logic                  accept, issue_fire, resp_take, resp_last;

`ifdef STACKCACHE_XFER_CRITICAL_WORD_FIRST_EN
  assign start_idx = req_addr[LINE_IDX_W-1:0];
`else
  assign start_idx = '0;
`endif

  assign accept     = (state_q == IDLE) && req_valid && clk_en;
  assign issue_fire = mem.mem_req_valid && mem.mem_req_ready;
  assign resp_take  = (state_q == XFER) && mem.mem_resp_valid && !resp_full && !sync_rst;
  assign resp_last  = resp_take && (resp_cnt == LINE_IDX_W'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      line_q  <= '0;
    end else if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            cmd_q   <= '{write: req_write,
                         base:  req_addr & ~ADDR_W'(LINE_WORDS - 1),
                         start: start_idx,
                         slot:  req_slot};
            line_q  <= req_line_data;
            state_q <= XFER;
          end
        end
        XFER:    if (resp_last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  stack_line_word_counter u_issue_cnt (
    .clk      (clk),
    .clk_en   (clk_en),
    .sync_rst (sync_rst),
    .clr      (accept),
    .inc      (issue_fire),
    .count    (issue_cnt),
    .full     (issue_full)
  );

  stack_line_word_counter u_resp_cnt (
    .clk      (clk),
    .clk_en   (clk_en),
    .sync_rst (sync_rst),
    .clr      (accept),
    .inc      (resp_take),
    .count    (resp_cnt),
    .full     (resp_full)
  );

  // Index arithmetic is LINE_IDX_W wide, so wrap stays inside the line.
  assign issue_idx = cmd_q.start + issue_cnt;

  assign req_ready         = (state_q == IDLE);
  assign mem.mem_req_valid = (state_q == XFER) && !issue_full;
  assign mem.mem_req_write = cmd_q.write;
  assign mem.mem_req_addr  = cmd_q.base | ADDR_W'(issue_idx);
  assign mem.mem_req_data  = cmd_q.write ? line_q[issue_idx] : '0;

  assign fill_valid = clk_en && resp_take && !cmd_q.write;
  assign fill_slot  = cmd_q.slot;
  assign fill_index = cmd_q.start + resp_cnt;
  assign fill_data  = fill_valid ? mem.mem_resp_data : '0;

  assign done_valid = clk_en && !sync_rst && (state_q == DONE);
  assign done_slot  = cmd_q.slot;
  assign done_write = cmd_q.write;

endmodule

// File: tb/tb_stack_line_xfer_responder.sv
// Randomized bench for stack_line_xfer_responder against a line-level transfer model.
module tb_stack_line_xfer_responder;
  import stackcache_pkg::*;

  logic                         clk = 1'b0;
  logic                         clk_en, sync_rst, req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [SLOT_W-1:0]            req_slot;
  logic [LINE_WORDS*DATA_W-1:0] req_line_data;
  logic                         fill_valid, done_valid, done_write;
  logic [SLOT_W-1:0]            fill_slot, done_slot;
  logic [LINE_IDX_W-1:0]        fill_index;
  logic [DATA_W-1:0]            fill_data;

  stack_line_xfer_responder_if mif ();

  stack_line_xfer_responder dut (
    .clk           (clk),
    .clk_en        (clk_en),
    .sync_rst      (sync_rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_slot      (req_slot),
    .req_line_data (req_line_data),
    .mem           (mif),
    .fill_valid    (fill_valid),
    .fill_slot     (fill_slot),
    .fill_index    (fill_index),
    .fill_data     (fill_data),
    .done_valid    (done_valid),
    .done_slot     (done_slot),
    .done_write    (done_write)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] addr; logic wr; logic [15:0] data;} iss_t;
  typedef struct {int idx; logic [15:0] data;} fill_t;
  typedef struct {logic [15:0] addr; logic wr; int due;} pend_t;

  iss_t  exp_iss[$];
  fill_t exp_fill[$];
  pend_t pend[$];
  iss_t  e;
  fill_t f;
  pend_t p;

  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, acc_cyc = 0, done_cyc = 0, fill_cnt = 0, done_cnt = 0;
  int   rdy_mode = 0, mem_delay = 1;
  bit   exp_busy = 0, exp_wr = 0;
  logic [1:0] exp_slot = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Memory model plus output monitor; runs 1-2 time units after each falling edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       mif.mem_req_ready = 1'b1;
      1:       mif.mem_req_ready = ~mif.mem_req_ready;
      default: mif.mem_req_ready = 1'($urandom_range(0, 1));
    endcase
    if (sync_rst) pend.delete();
    if (clk_en && !sync_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      mif.mem_resp_valid = 1'b1;
      mif.mem_resp_data  = pend[0].wr ? 16'($urandom) : rd_val(pend[0].addr);
    end else begin
      mif.mem_resp_valid = 1'b0;
      mif.mem_resp_data  = 16'($urandom);
    end
    #1;
    if (clk_en && !sync_rst) begin
      if (exp_busy) check("busy_ready", 32'(req_ready), 32'd0);
      if (mif.mem_req_valid && mif.mem_req_ready) begin
        if (exp_iss.size() == 0) check("extra_issue", 32'd1, 32'd0);
        else begin
          e = exp_iss.pop_front();
          check("iss_addr", 32'(mif.mem_req_addr), 32'(e.addr));
          check("iss_write", 32'(mif.mem_req_write), 32'(e.wr));
          if (e.wr) check("iss_data", 32'(mif.mem_req_data), 32'(e.data));
        end
        pend.push_back('{addr: mif.mem_req_addr, wr: mif.mem_req_write, due: cyc + mem_delay});
      end
      if (mif.mem_resp_valid) begin
        check("proto_idle_resp", 32'(req_ready), 32'd0);
        p = pend.pop_front();
        if (!p.wr) begin
          if (exp_fill.size() == 0) check("extra_fill", 32'd1, 32'd0);
          else begin
            f = exp_fill.pop_front();
            check("fill_valid", 32'(fill_valid), 32'd1);
            check("fill_index", 32'(fill_index), 32'(f.idx));
            check("fill_data", 32'(fill_data), 32'(f.data));
            check("fill_slot", 32'(fill_slot), 32'(exp_slot));
          end
          fill_cnt++;
        end else check("wb_no_fill", 32'(fill_valid), 32'd0);
      end else check("no_fill", 32'(fill_valid), 32'd0);
      if (done_valid) begin
        check("done_expected", 32'(exp_busy), 32'd1);
        check("done_slot", 32'(done_slot), 32'(exp_slot));
        check("done_write", 32'(done_write), 32'(exp_wr));
        check("done_issues_left", 32'(exp_iss.size()), 32'd0);
        check("done_fills_left", 32'(exp_fill.size()), 32'd0);
        exp_busy = 0;
        done_cyc = cyc;
        done_cnt++;
      end
    end else begin
      check("gated_fill", 32'(fill_valid), 32'd0);
      check("gated_done", 32'(done_valid), 32'd0);
    end
  end

  // Call at a falling edge; returns at the next falling edge (hold=0) or in the accept cycle.
  task automatic start_cmd(input logic wr, input logic [15:0] addr, input logic [1:0] slot,
                           input logic [127:0] line, input bit hold);
    bit acc = 0;
    int st;
    logic [15:0] base, a;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_slot = slot; req_line_data = line;
    for (int i = 0; i < 300 && !acc; i++) begin
      #3;
      if (req_ready && clk_en && !sync_rst) begin
        acc  = 1;
        base = addr & 16'hFFF8;
`ifdef STACKCACHE_XFER_CRITICAL_WORD_FIRST_EN
        st = int'(addr[2:0]);
`else
        st = 0;
`endif
        for (int k = 0; k < LINE_WORDS; k++) begin
          int idx;
          idx = (st + k) % LINE_WORDS;
          a   = base + 16'(idx);
          exp_iss.push_back('{addr: a, wr: wr, data: line[idx*16 +: 16]});
          if (!wr) exp_fill.push_back('{idx: idx, data: rd_val(a)});
        end
        exp_busy = 1; exp_slot = slot; exp_wr = wr; acc_cyc = cyc;
      end else @(negedge clk);
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] line;
    int f0;
    clk_en = 1'b1; sync_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_slot = '0; req_line_data = '0;
    mif.mem_req_ready = 1'b1; mif.mem_resp_valid = 1'b0; mif.mem_resp_data = '0;
    repeat (3) @(negedge clk);
    sync_rst = 1'b0;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mif.mem_req_valid), 32'd0);
    check("rst_mem_addr", 32'(mif.mem_req_addr), 32'd0);
    check("rst_mem_write", 32'(mif.mem_req_write), 32'd0);
    check("rst_fill_valid", 32'(fill_valid), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_slot", 32'(done_slot), 32'd0);
    @(negedge clk);

    // Zero-wait fetch with latency check
    rdy_mode = 0; mem_delay = 1;
    start_cmd(1'b0, 16'h0100, 2'd2, 128'd0, 1'b0);
    wait_done(60);
    check("fetch_latency", 32'(done_cyc - acc_cyc), 32'(LINE_WORDS + 2));

    // Writeback of 0x1000..0x1007
    for (int k = 0; k < LINE_WORDS; k++) line[k*16 +: 16] = 16'h1000 + 16'(k);
    start_cmd(1'b1, 16'h0200, 2'd1, line, 1'b0);
    wait_done(60);

    // Unaligned address: start word depends on the build option
    start_cmd(1'b0, 16'h0105, 2'd3, 128'd0, 1'b0);
    wait_done(60);

    // Backpressure, delayed responses and a clock-enable freeze
    rdy_mode = 1; mem_delay = 3;
    start_cmd(1'b0, 16'h0340, 2'd0, 128'd0, 1'b0);
    repeat (3) @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (exp_iss.size() > 0) begin
        check("frz_req_valid", 32'(mif.mem_req_valid), 32'd1);
        check("frz_req_addr", 32'(mif.mem_req_addr), 32'(exp_iss[0].addr));
      end
      @(negedge clk);
    end
    clk_en = 1'b1;
    wait_done(200);

    // Reset abort after three fill words
    rdy_mode = 0; mem_delay = 1;
    f0 = fill_cnt;
    start_cmd(1'b0, 16'h0480, 2'd2, 128'd0, 1'b0);
    for (int i = 0; i < 100 && fill_cnt - f0 < 3; i++) @(negedge clk);
    check("abort_fill_count", 32'(fill_cnt - f0), 32'd3);
    sync_rst = 1'b1;
    exp_iss.delete(); exp_fill.delete(); exp_busy = 0;
    @(negedge clk);
    sync_rst = 1'b0;
    #3;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_valid", 32'(mif.mem_req_valid), 32'd0);
    f0 = done_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - f0), 32'd0);
    start_cmd(1'b0, 16'h0488, 2'd1, 128'd0, 1'b0);
    wait_done(60);

    // Held request at the top line: second command only after done
    line = {$urandom, $urandom, $urandom, $urandom};
    start_cmd(1'b0, 16'hFFFB, 2'd3, line, 1'b1);
    wait_done(60);
    start_cmd(1'b1, 16'hFFFB, 2'd3, line, 1'b0);
    check("held_accept_gap", 32'(acc_cyc - done_cyc), 32'd1);
    wait_done(60);

    // Randomized traffic
    for (int k = 0; k < 10; k++) begin
      rdy_mode  = 2;
      mem_delay = int'($urandom_range(1, 4));
      line      = {$urandom, $urandom, $urandom, $urandom};
      start_cmd(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), line, 1'b0);
      wait_done(300);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
